carregador_programa: RTL and testbench
======================================

# carregador_programa

Byte-stream program loader that writes the write port of the 16-bit program memory. It accepts framed bytes from a host link (UART receiver or debug bridge) with a valid/ready handshake, assembles them into memory words MSB-first, and issues sequential writes starting at a header-supplied address. It holds the Forth CPU in reset via `cpu_hold` while a load is in progress.

## Interface
- `DATA_WIDTH`, 16, memory word width; multiple of 8, range 8..32
- `ADDR_WIDTH`, 16, memory address width; range 1..16
- `clock`  in  1  single clock; also drives the memory `write_clock`
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; arms a new load from IDLE, DONE or ERROR
- `byte_in`  in  8  frame byte
- `byte_valid`  in  1  `byte_in` valid
- `byte_ready`  out  1  loader accepts a byte this cycle
- `mem_data`  out  DATA_WIDTH  to memory `data`
- `mem_addr`  out  ADDR_WIDTH  to memory `write_addr`
- `mem_we`  out  1  to memory `we`; one-cycle pulse per word
- `busy`  out  1  load in progress
- `cpu_hold`  out  1  equals `busy`
- `done`  out  1  sticky; frame completed successfully
- `error`  out  1  sticky; checksum mismatch

## Operation
- Frame: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words of DATA_WIDTH/8 bytes each (MSB first), then optional checksum byte.
- Start address and count are 16-bit; the address is truncated to its low ADDR_WIDTH bits.
- A byte is accepted on a cycle where `byte_valid && byte_ready` is true. Bytes offered while `byte_ready`=0 are ignored, not queued.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR.
  - `start` in IDLE, DONE or ERROR → ADDR_HI. This clears `done` and `error` and sets `busy`.
  - Each header state advances on one accepted byte.
  - From CNT_LO: CNT=0 → CHECK (macro on) or DONE (macro off); otherwise → DATA.
  - DATA shifts bytes into the word register. When the last byte of a word is accepted, a write is issued and the word counter decrements. When the counter reaches 0 → CHECK or DONE.
  - CHECK accepts one byte. A match → DONE, a mismatch → ERROR.
- `start` while busy is ignored.
- `byte_ready`=1 in ADDR_HI..CHECK and 0 in IDLE, DONE and ERROR.
- The write address increments by 1 after each write and wraps modulo 2**ADDR_WIDTH.
- Words already written before an ERROR remain in memory. There is no rollback.
- Reset mid-load aborts the load immediately and returns to IDLE. Partial words are discarded.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_data`=0, `mem_addr`=0, `busy`=0, `cpu_hold`=0, `done`=0, `error`=0. State is IDLE.
- `busy` and `byte_ready` rise on the cycle after `start`.
- `mem_we`, `mem_addr` and `mem_data` are registered. `mem_we` is high exactly one cycle, on the cycle after the last byte of a word is accepted. The memory captures the word on the following `clock` edge.
- Back-to-back bytes are sustained at one byte per cycle with no stall; throughput is one word per DATA_WIDTH/8 cycles.
- `done`, or `error`, rises on the cycle after the final frame byte is accepted. On the same edge `busy` falls. The last word's `mem_we` pulse coincides with `done` (macro off) or precedes it (macro on).
- `done` and `error` are never high simultaneously.

## Configuration
- `LOADER_CHECKSUM_EN` defined: the frame ends with a checksum byte, and CHECK is used.
  - The checksum is the 8-bit modular sum of all preceding frame bytes, header included.
  - Sum equal to the checksum byte → DONE; otherwise → ERROR.
- Not defined: no CHECK state; the frame ends after the last data word, and `error` is tied to 0.

## Test plan
- Macro off: `start`, then bytes 00 10 00 02 12 34 AB CD at one byte per cycle → writes 0x1234@0x0010 and 0xABCD@0x0011, each `mem_we` one cycle wide. `done`=1 and `busy`=0 one cycle after byte CD.
- Macro on: frame 00 00 00 01 BE EF with checksum 0xAE → 0xBEEF@0x0000, then `done`=1. The same frame with checksum 0xAF → 0xBEEF still written, then `error`=1 and `done`=0.
- Wrap: ADDR_WIDTH=4, start address 0x000F, count 2, words 1111 2222 → writes at 0xF then 0x0.
- Count 0 (macro off): 00 05 00 00 → no `mem_we`, and `done`=1 one cycle after the fourth byte.
- `byte_valid` toggling every other cycle, plus `start` pulsed mid-load → same writes as the gap-free case, and `start` has no effect.
- `reset` asserted after the first byte of a data word → next cycle all outputs are at reset values and no write is issued. A following full frame loads correctly.

Source files
------------

// File: rtl/carregador_programa.sv
// Byte-stream program loader: framed bytes in, sequential 16-bit memory writes out.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module carregador_programa #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int BPW = DATA_WIDTH / 8;

    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR
    } state_t;

    state_t                state;
    logic [7:0]            addr_hi;
    logic [15:0]           cnt;
    logic [15:0]           cnt_next;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH+7:0] cat;
    logic [1:0]            bidx;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  accept;
    logic                  last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum;
`endif

    always_comb begin
        busy       = (state != IDLE) && (state != DONE) && (state != ERROR);
        byte_ready = busy;
        cpu_hold   = busy;
        accept     = byte_valid && byte_ready;
        cat        = {word, byte_in};
        cnt_next   = {cnt[15:8], byte_in};
        last_byte  = (bidx == 2'(BPW - 1));
    end

`ifndef LOADER_CHECKSUM_EN
    assign error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            addr_hi  <= '0;
            cnt      <= '0;
            word     <= '0;
            bidx     <= '0;
            wr_addr  <= '0;
            mem_we   <= 1'b0;
            mem_data <= '0;
            mem_addr <= '0;
            done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            error    <= 1'b0;
            sum      <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (accept) sum <= sum + byte_in;
`endif
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state <= ADDR_HI;
                        done  <= 1'b0;
                        bidx  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        error <= 1'b0;
                        sum   <= '0;
`endif
                    end
                end
                ADDR_HI: begin
                    if (accept) begin
                        addr_hi <= byte_in;
                        state   <= ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (accept) begin
                        wr_addr <= ADDR_WIDTH'({addr_hi, byte_in});
                        state   <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (accept) begin
                        cnt[15:8] <= byte_in;
                        state     <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (accept) begin
                        cnt <= cnt_next;
                        if (cnt_next == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state <= DONE;
                            done  <= 1'b1;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        word <= cat[DATA_WIDTH-1:0];
                        if (last_byte) begin
                            bidx     <= '0;
                            mem_we   <= 1'b1;
                            mem_data <= cat[DATA_WIDTH-1:0];
                            mem_addr <= wr_addr;
                            wr_addr  <= wr_addr + ADDR_WIDTH'(1);
                            cnt      <= cnt - 16'd1;
                            // Last word of the frame: finish on this same edge
                            if (cnt == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= CHECK;
`else
                                state <= DONE;
                                done  <= 1'b1;
`endif
                            end
                        end else begin
                            bidx <= bidx + 2'd1;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (byte_in == sum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa, main instance plus a 4-bit-address
// instance for the wrap case; follows LOADER_CHECKSUM_EN if defined.
module tb_carregador_programa;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        ready_a, we_a, busy_a, hold_a, done_a, error_a;
    logic [15:0] data_a, addr_a;
    logic        ready_w, we_w, busy_w, hold_w, done_w, error_w;
    logic [15:0] data_w;
    logic [3:0]  addr_w;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] la[$], ld[$], wa[$], wd[$];
    logic [7:0]  frame[$];

    always #5 clock = ~clock;

    carregador_programa #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_a),
        .mem_data(data_a), .mem_addr(addr_a), .mem_we(we_a),
        .busy(busy_a), .cpu_hold(hold_a), .done(done_a), .error(error_a)
    );

    carregador_programa #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_wrap (
        .clock(clock), .reset(reset), .start(start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_w),
        .mem_data(data_w), .mem_addr(addr_w), .mem_we(we_w),
        .busy(busy_w), .cpu_hold(hold_w), .done(done_w), .error(error_w)
    );

    // Every high cycle of mem_we is logged, so a two-cycle pulse shows up as an extra write
    always @(negedge clock) begin
        if (we_a) begin
            la.push_back(32'(addr_a));
            ld.push_back(32'(data_a));
        end
        if (we_w) begin
            wa.push_back(32'(addr_w));
            wd.push_back(32'(data_w));
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic clear_logs();
        la.delete(); ld.delete(); wa.delete(); wd.delete();
    endtask

    task automatic run_frame(input bit gaps, input bit add_sum);
        logic [7:0] s;
        int n;
        s = 8'h00;
        foreach (frame[i]) s = s + frame[i];
`ifdef LOADER_CHECKSUM_EN
        if (add_sum) frame.push_back(s);
`endif
        n = frame.size();
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) check("done_early", 32'(done_a), 32'h0);
            send(frame[i]);
            if (gaps) begin
                byte_in = 8'h5A;
                start   = (i == 3);
                tick();
                start   = 1'b0;
            end
        end
    endtask

    task automatic check_log(input string tag, input bit wrap, input int n,
                             input logic [31:0] a0, input logic [31:0] d0,
                             input logic [31:0] a1, input logic [31:0] d1);
        logic [31:0] ea[2];
        logic [31:0] ed[2];
        logic [31:0] ga, gd;
        int sz;
        ea[0] = a0; ea[1] = a1; ed[0] = d0; ed[1] = d1;
        sz = wrap ? wa.size() : la.size();
        check({tag, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n; i++) begin
            ga = 32'hDEAD_DEAD;
            gd = 32'hDEAD_DEAD;
            if (i < sz) begin
                ga = wrap ? wa[i] : la[i];
                gd = wrap ? wd[i] : ld[i];
            end
            check({tag, "_addr"}, ga, ea[i]);
            check({tag, "_data"}, gd, ed[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready_a), 32'h0);
        check({tag, "_we"},    32'(we_a),    32'h0);
        check({tag, "_data"},  32'(data_a),  32'h0);
        check({tag, "_addr"},  32'(addr_a),  32'h0);
        check({tag, "_busy"},  32'(busy_a),  32'h0);
        check({tag, "_hold"},  32'(hold_a),  32'h0);
        check({tag, "_done"},  32'(done_a),  32'h0);
        check({tag, "_error"}, 32'(error_a), 32'h0);
    endtask

    task automatic finish_ok(input string tag);
        check({tag, "_done"},  32'(done_a),  32'h1);
        check({tag, "_error"}, 32'(error_a), 32'h0);
        check({tag, "_busy"},  32'(busy_a),  32'h0);
        check({tag, "_hold"},  32'(hold_a),  32'h0);
        check({tag, "_ready"}, 32'(ready_a), 32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // A byte offered in IDLE must be dropped
        send(8'h77);
        check("idle_ready", 32'(ready_a), 32'h0);

        // Back-to-back frame: two words at 0x0010
        clear_logs();
        pulse_start();
        check("start_busy",  32'(busy_a),  32'h1);
        check("start_ready", 32'(ready_a), 32'h1);
        check("start_hold",  32'(hold_a),  32'h1);
        frame = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        run_frame(1'b0, 1'b1);
        finish_ok("a");
`ifdef LOADER_CHECKSUM_EN
        check("a_we_at_done", 32'(we_a), 32'h0);
`else
        check("a_we_at_done", 32'(we_a), 32'h1);
`endif
        tick();
        check_log("a", 1'b0, 2, 32'h10, 32'h1234, 32'h11, 32'hABCD);

        // Zero-count frame produces no writes
        clear_logs();
        pulse_start();
        frame = '{8'h00, 8'h05, 8'h00, 8'h00};
        run_frame(1'b0, 1'b1);
        finish_ok("cnt0");
        tick();
        tick();
        check_log("cnt0", 1'b0, 0, 0, 0, 0, 0);

        // Gapped bytes with a stray start while busy
        clear_logs();
        pulse_start();
        frame = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        run_frame(1'b1, 1'b1);
        finish_ok("gap");
        tick();
        check_log("gap", 1'b0, 2, 32'h10, 32'h1234, 32'h11, 32'hABCD);

        // Address wrap on the 4-bit instance
        clear_logs();
        pulse_start();
        frame = '{8'h00, 8'h0F, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
        run_frame(1'b0, 1'b1);
        check("wrap_done", 32'(done_w), 32'h1);
        tick();
        check_log("wrap", 1'b1, 2, 32'hF, 32'h1111, 32'h0, 32'h2222);

        // Reset after the first byte of a data word
        clear_logs();
        pulse_start();
        send(8'h00); send(8'h20); send(8'h00); send(8'h01); send(8'h12);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        tick();
        tick();
        check_log("mid_rst", 1'b0, 0, 0, 0, 0, 0);
        pulse_start();
        frame = '{8'h00, 8'h30, 8'h00, 8'h01, 8'h56, 8'h78};
        run_frame(1'b0, 1'b1);
        finish_ok("post_rst");
        tick();
        check_log("post_rst", 1'b0, 1, 32'h30, 32'h5678, 0, 0);

        // Single word at 0x0000; explicit checksum bytes when enabled
        clear_logs();
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        frame.push_back(8'hAE);
`endif
        run_frame(1'b0, 1'b0);
        finish_ok("beef");
        tick();
        check_log("beef", 1'b0, 1, 32'h0, 32'hBEEF, 0, 0);

`ifdef LOADER_CHECKSUM_EN
        clear_logs();
        pulse_start();
        check("err_clr_done", 32'(done_a), 32'h0);
        frame = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'hAF};
        run_frame(1'b0, 1'b0);
        check("bad_error", 32'(error_a), 32'h1);
        check("bad_done",  32'(done_a),  32'h0);
        check("bad_busy",  32'(busy_a),  32'h0);
        tick();
        check_log("bad", 1'b0, 1, 32'h0, 32'hBEEF, 0, 0);
        pulse_start();
        check("bad_restart_error", 32'(error_a), 32'h0);
        check("bad_restart_busy",  32'(busy_a),  32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
